// File: rtl/up_core_8b_if.sv
// up_core_8b_if: external I/O bundle of the up_core_8b microprocessor.
//   master - the environment (drives the interrupt line and the input byte)
//   slave  - the core (drives the mirrored output byte)
// The interrupt line is called int_n because "int" is a reserved word.
interface up_core_8b_if;
    logic       int_n;        // interrupt request, active low; a falling edge requests service
    logic       mem_map_load; // when high, mem_map_in is written to the input byte this edge
    logic [7:0] mem_map_in;   // external input byte
    logic [7:0] mem_map_out;  // live copy of the output byte

    modport master (output int_n, output mem_map_load, output mem_map_in, input mem_map_out);
    modport slave  (input int_n, input mem_map_load, input mem_map_in, output mem_map_out);
endinterface

// File: rtl/up_core_8b.sv
// up_core_8b: 8-bit accumulator microprocessor with a 256-byte unified
// code/data memory (mem[0:255]), a memory-mapped input byte at IN_ADDR and
// a memory-mapped output byte at OUT_ADDR.
// Instruction timing: FETCH -> [OPER] -> EXEC; 1-byte ops take 2 cycles,
// 2-byte ops (opcodes 1..B) take 3 cycles.
// Optional feature macro: UP_CORE_INT_EN enables the single active-low
// interrupt (EI/DI/RETI, shadow PC/flags). Without it the interrupt pin is
// ignored, EI/DI/RETI are NOPs and HALT lasts until reset.
// Reset (nRst) is synchronous and active-high.
module up_core_8b #(
    parameter logic [7:0] INT_VEC  = 8'hE0,
    parameter logic [7:0] IN_ADDR  = 8'hFE,
    parameter logic [7:0] OUT_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        nRst,
    up_core_8b_if.slave bus
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_OPER,
        S_EXEC
    } state_t;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_LDI  = 4'h1;
    localparam logic [3:0] OPC_LD   = 4'h2;
    localparam logic [3:0] OPC_ST   = 4'h3;
    localparam logic [3:0] OPC_ADD  = 4'h4;
    localparam logic [3:0] OPC_SUB  = 4'h5;
    localparam logic [3:0] OPC_AND  = 4'h6;
    localparam logic [3:0] OPC_OR   = 4'h7;
    localparam logic [3:0] OPC_XOR  = 4'h8;
    localparam logic [3:0] OPC_JMP  = 4'h9;
    localparam logic [3:0] OPC_JZ   = 4'hA;
    localparam logic [3:0] OPC_JC   = 4'hB;
    localparam logic [3:0] OPC_EI   = 4'hC;
    localparam logic [3:0] OPC_DI   = 4'hD;
    localparam logic [3:0] OPC_RETI = 4'hE;
    localparam logic [3:0] OPC_HALT = 4'hF;

    logic [7:0] mem [0:255];

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] a_q, a_d;
    logic [7:0] op_q, op_d;
    logic [3:0] opc_q, opc_d;     // only IR[7:4] matters, so only that is kept
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       halted_q, halted_d;
    logic       st_we;
    logic       take_int;

    logic [3:0] fetch_opc;
    logic [7:0] operand;
    logic [8:0] sum;
    logic [8:0] diff;

    assign fetch_opc = mem[pc_q][7:4];
    assign operand   = mem[op_q];
    assign sum       = {1'b0, a_q} + {1'b0, operand};
    assign diff      = {1'b0, a_q} - {1'b0, operand};   // diff[8] is the borrow

`ifdef UP_CORE_INT_EN
    logic       ie_q, ie_d;
    logic       pending_q, pending_d;
    logic       int_q, int_d;
    logic [7:0] spc_q, spc_d;
    logic       sz_q, sz_d;
    logic       sc_q, sc_d;

    assign take_int = pending_q & ie_q;
`else
    logic unused_int;

    assign unused_int = bus.int_n;
    assign take_int   = 1'b0;
`endif

    // Next-state, datapath and store-enable for one FETCH/OPER/EXEC step.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d  = state_q;
        pc_d     = pc_q;
        a_d      = a_q;
        op_d     = op_q;
        opc_d    = opc_q;
        z_d      = z_q;
        c_d      = c_q;
        halted_d = halted_q;
        st_we    = 1'b0;
`ifdef UP_CORE_INT_EN
        ie_d      = ie_q;
        pending_d = pending_q;
        int_d     = bus.int_n;
        spc_d     = spc_q;
        sz_d      = sz_q;
        sc_d      = sc_q;
`endif

        unique case (state_q)
            S_FETCH: begin
                if (take_int) begin
                    // Interrupt entry replaces this fetch; it also wakes a halted core.
`ifdef UP_CORE_INT_EN
                    spc_d     = pc_q;
                    sz_d      = z_q;
                    sc_d      = c_q;
                    ie_d      = 1'b0;
                    pending_d = 1'b0;
`endif
                    pc_d     = INT_VEC;
                    halted_d = 1'b0;
                end else if (!halted_q) begin
                    opc_d   = fetch_opc;
                    pc_d    = pc_q + 8'd1;
                    state_d = (fetch_opc != OPC_NOP && fetch_opc <= OPC_JC) ? S_OPER : S_EXEC;
                end
            end

            S_OPER: begin
                op_d    = mem[pc_q];
                pc_d    = pc_q + 8'd1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (opc_q)
                    OPC_LDI: begin a_d = op_q;    z_d = (op_q == 8'd0);    end
                    OPC_LD:  begin a_d = operand; z_d = (operand == 8'd0); end
                    OPC_ST:  st_we = 1'b1;
                    OPC_ADD: begin a_d = sum[7:0];  c_d = sum[8];  z_d = (sum[7:0] == 8'd0);  end
                    OPC_SUB: begin a_d = diff[7:0]; c_d = diff[8]; z_d = (diff[7:0] == 8'd0); end
                    OPC_AND: begin a_d = a_q & operand; z_d = ((a_q & operand) == 8'd0); end
                    OPC_OR:  begin a_d = a_q | operand; z_d = ((a_q | operand) == 8'd0); end
                    OPC_XOR: begin a_d = a_q ^ operand; z_d = ((a_q ^ operand) == 8'd0); end
                    OPC_JMP: pc_d = op_q;
                    OPC_JZ:  if (z_q) pc_d = op_q;
                    OPC_JC:  if (c_q) pc_d = op_q;
`ifdef UP_CORE_INT_EN
                    OPC_EI:  ie_d = 1'b1;
                    OPC_DI:  ie_d = 1'b0;
                    OPC_RETI: begin
                        pc_d = spc_q;
                        z_d  = sz_q;
                        c_d  = sc_q;
                        ie_d = 1'b1;
                    end
`endif
                    OPC_HALT: halted_d = 1'b1;
                    default: ;
                endcase
            end

            default: state_d = S_FETCH;
        endcase

`ifdef UP_CORE_INT_EN
        // A falling edge sets pending; one arriving while already pending merges into it.
        if (int_q && !bus.int_n) pending_d = 1'b1;
`endif
    end

    // Core registers with synchronous active-high reset; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (nRst) begin
            state_q  <= S_FETCH;
            pc_q     <= 8'd0;
            a_q      <= 8'd0;
            op_q     <= 8'd0;
            opc_q    <= 4'd0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            halted_q <= 1'b0;
`ifdef UP_CORE_INT_EN
            ie_q      <= 1'b0;
            pending_q <= 1'b0;
            int_q     <= 1'b1;
            spc_q     <= 8'd0;
            sz_q      <= 1'b0;
            sc_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            op_q     <= op_d;
            opc_q    <= opc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            halted_q <= halted_d;
`ifdef UP_CORE_INT_EN
            ie_q      <= ie_d;
            pending_q <= pending_d;
            int_q     <= int_d;
            spc_q     <= spc_d;
            sz_q      <= sz_d;
            sc_q      <= sc_d;
`endif
        end
    end

    // Memory write port: core store (suppressed in reset), then external input load, which wins.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; its contents survive reset and are preloaded externally.
        if (st_we && !nRst) mem[op_q] <= a_q;
        if (bus.mem_map_load) mem[IN_ADDR] <= bus.mem_map_in;
    end

    assign bus.mem_map_out = mem[OUT_ADDR];

endmodule

// File: tb/tb_up_core_8b.sv
// tb_up_core_8b: directed test of up_core_8b against an instruction-level
// model that charges each instruction 2 or 3 cycles and applies its effect
// on the last one. Follows the UP_CORE_INT_EN build setting of the RTL.
module tb_up_core_8b;

    localparam logic [7:0] IN_A  = 8'hFE;
    localparam logic [7:0] OUT_A = 8'hFF;
    localparam logic [7:0] VEC   = 8'hE0;

    logic clk = 1'b0;
    logic nRst;

    up_core_8b_if bus_if ();

    up_core_8b dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction-level model
    // ------------------------------------------------------------------
    logic [7:0] m_mem [256];
    logic [7:0] m_pc, m_a, m_ir, m_op, m_spc;
    logic       m_z, m_c, m_halt, m_ie, m_pend, m_intq, m_sz, m_sc, m_fall;
    int         m_cnt;    // cycles still owed by the current instruction; 0 = at a boundary
    int         m_sum;

    task model_exec();
        case (m_ir[7:4])
            4'h1: begin m_a = m_op; m_z = (m_a == 8'd0); end
            4'h2: begin m_a = m_mem[m_op]; m_z = (m_a == 8'd0); end
            4'h3: m_mem[m_op] = m_a;
            4'h4: begin
                m_sum = int'(m_a) + int'(m_mem[m_op]);
                m_c   = (m_sum > 255);
                m_a   = m_sum[7:0];
                m_z   = (m_a == 8'd0);
            end
            4'h5: begin
                m_c = (m_a < m_mem[m_op]);
                m_a = m_a - m_mem[m_op];
                m_z = (m_a == 8'd0);
            end
            4'h6: begin m_a = m_a & m_mem[m_op]; m_z = (m_a == 8'd0); end
            4'h7: begin m_a = m_a | m_mem[m_op]; m_z = (m_a == 8'd0); end
            4'h8: begin m_a = m_a ^ m_mem[m_op]; m_z = (m_a == 8'd0); end
            4'h9: m_pc = m_op;
            4'hA: if (m_z) m_pc = m_op;
            4'hB: if (m_c) m_pc = m_op;
`ifdef UP_CORE_INT_EN
            4'hC: m_ie = 1'b1;
            4'hD: m_ie = 1'b0;
            4'hE: begin m_pc = m_spc; m_z = m_sz; m_c = m_sc; m_ie = 1'b1; end
`endif
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    always begin
        @(posedge clk);
        if (nRst === 1'b1) begin
            m_pc = 8'd0; m_a = 8'd0; m_z = 1'b0; m_c = 1'b0; m_halt = 1'b0;
            m_ie = 1'b0; m_pend = 1'b0; m_intq = 1'b1; m_cnt = 0;
            m_spc = 8'd0; m_sz = 1'b0; m_sc = 1'b0;
        end else begin
            m_fall = 1'b0;
`ifdef UP_CORE_INT_EN
            m_fall = m_intq && !bus_if.int_n;
            m_intq = bus_if.int_n;
`endif
            if (m_cnt == 0) begin
                if (m_pend && m_ie) begin
                    m_spc = m_pc; m_sz = m_z; m_sc = m_c;
                    m_ie = 1'b0; m_pend = 1'b0; m_halt = 1'b0;
                    m_pc = VEC;
                end else if (!m_halt) begin
                    m_ir  = m_mem[m_pc];
                    m_pc  = m_pc + 8'd1;
                    m_cnt = (m_ir[7:4] >= 4'h1 && m_ir[7:4] <= 4'hB) ? 2 : 1;
                end
            end else if (m_cnt == 2) begin
                m_op  = m_mem[m_pc];
                m_pc  = m_pc + 8'd1;
                m_cnt = 1;
            end else begin
                model_exec();
                m_cnt = 0;
            end
            if (m_fall) m_pend = 1'b1;
        end
        if (bus_if.mem_map_load === 1'b1) m_mem[IN_A] = bus_if.mem_map_in;
    end

    // Compare process: output byte every cycle, architectural state at instruction boundaries.
    always begin
        @(negedge clk);
        #1;
        if (started) begin
            check("out_byte", bus_if.mem_map_out, m_mem[OUT_A]);
            if (m_cnt == 0) begin
                check("arch_pc_a_z_c_halt",
                      {dut.pc_q, dut.a_q, dut.z_q, dut.c_q, dut.halted_q},
                      {m_pc, m_a, m_z, m_c, m_halt});
`ifdef UP_CORE_INT_EN
                check("irq_ie_pend", {dut.ie_q, dut.pending_q}, {m_ie, m_pend});
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic poke(input logic [7:0] addr, input logic [7:0] data);
        dut.mem[addr] = data;
        m_mem[addr]   = data;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rst_on();
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_int();
        bus_if.int_n = 1'b0;
        run(1);
        bus_if.int_n = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (dut.halted_q === 1'b1) break;
            @(negedge clk);
        end
        check({name, "_halt_in_budget"}, (i < budget), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        nRst                = 1'b1;
        bus_if.int_n        = 1'b1;
        bus_if.mem_map_load = 1'b0;
        bus_if.mem_map_in   = 8'h00;
        run(2);
        for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);
        started = 1'b1;
        run(1);

        // Reset state
        check("rst_pc", dut.pc_q, 8'h00);
        check("rst_a", dut.a_q, 8'h00);
        check("rst_zch", {dut.z_q, dut.c_q, dut.halted_q}, 3'b000);

        // LDI 5A; ST FF; HALT -> output byte 5A on the sixth edge (LDI 3 + ST 3)
        poke(8'h00, 8'h10); poke(8'h01, 8'h5A); poke(8'h02, 8'h30); poke(8'h03, 8'hFF);
        poke(8'h04, 8'hF0);
        nRst = 1'b0;
        k = 0;
        while (bus_if.mem_map_out !== 8'h5A && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("t1_out_edge", k, 6);
        wait_halt("t1", 10);
        check("t1_pc", dut.pc_q, 8'h05);
        check("t1_a", dut.a_q, 8'h5A);

        // ADD carry, JC taken, SUB to zero
        rst_on();
        poke(8'h80, 8'h20); poke(8'h81, 8'h10); poke(8'h82, 8'h00);
        poke(8'h00, 8'h10); poke(8'h01, 8'hF0);   // LDI F0
        poke(8'h02, 8'h40); poke(8'h03, 8'h80);   // ADD 80
        poke(8'h04, 8'h30); poke(8'h05, 8'h82);   // ST 82
        poke(8'h06, 8'hB0); poke(8'h07, 8'h0A);   // JC 0A
        poke(8'h08, 8'hF0);                       // HALT (not reached)
        poke(8'h0A, 8'h50); poke(8'h0B, 8'h81);   // SUB 81
        poke(8'h0C, 8'hF0);                       // HALT
        nRst = 1'b0;
        run(6);
        check("add_a", dut.a_q, 8'h10);
        check("add_czf", {dut.c_q, dut.z_q}, 2'b10);
        wait_halt("t2", 30);
        check("t2_pc_after_jc", dut.pc_q, 8'h0D);
        check("sub_a", dut.a_q, 8'h00);
        check("sub_zc", {dut.z_q, dut.c_q}, 2'b10);
        check("t2_stored", dut.mem[8'h82], 8'h10);

        // Input byte: load honoured in reset, then LD FE / ST FF
        rst_on();
        bus_if.mem_map_load = 1'b1; bus_if.mem_map_in = 8'h77;
        run(1);
        bus_if.mem_map_load = 1'b0;
        check("load_in_reset", dut.mem[IN_A], 8'h77);
        poke(8'h00, 8'h20); poke(8'h01, 8'hFE);   // LD FE
        poke(8'h02, 8'h30); poke(8'h03, 8'hFF);   // ST FF
        poke(8'h04, 8'hF0);
        nRst = 1'b0;
        bus_if.mem_map_load = 1'b1; bus_if.mem_map_in = 8'h33;
        run(1);
        bus_if.mem_map_load = 1'b0;
        wait_halt("t3", 20);
        check("load_out", bus_if.mem_map_out, 8'h33);

        // Load beats a core store to the input byte in the same edge
        rst_on();
        poke(8'h00, 8'h10); poke(8'h01, 8'h44);   // LDI 44
        poke(8'h02, 8'h30); poke(8'h03, 8'hFE);   // ST FE
        poke(8'h04, 8'hF0);
        nRst = 1'b0;
        run(5);
        bus_if.mem_map_load = 1'b1; bus_if.mem_map_in = 8'h99;
        run(1);
        bus_if.mem_map_load = 1'b0;
        check("load_priority", dut.mem[IN_A], 8'h99);
        wait_halt("t3b", 10);

        // Reset just before the ST execute edge: no store lands
        rst_on();
        poke(8'h90, 8'h00);
        poke(8'h00, 8'h10); poke(8'h01, 8'h77);   // LDI 77
        poke(8'h02, 8'h30); poke(8'h03, 8'h90);   // ST 90
        poke(8'h04, 8'hF0);
        nRst = 1'b0;
        run(5);
        nRst = 1'b1;
        run(1);
        check("abort_no_store", dut.mem[8'h90], 8'h00);
        check("abort_pc", dut.pc_q, 8'h00);

        // Branches: JZ taken, JZ not taken, JMP FE then PC wraps FF->00
        rst_on();
        poke(8'h00, 8'h10); poke(8'h01, 8'h00);   // LDI 00 (Z=1)
        poke(8'h02, 8'hA0); poke(8'h03, 8'h06);   // JZ 06 (taken)
        poke(8'h04, 8'hF0);
        poke(8'h06, 8'h10); poke(8'h07, 8'h01);   // LDI 01 (Z=0)
        poke(8'h08, 8'hA0); poke(8'h09, 8'h20);   // JZ 20 (falls through)
        poke(8'h0A, 8'h90); poke(8'h0B, 8'hFE);   // JMP FE
        poke(8'h20, 8'hF0);
        poke(8'hFE, 8'h00); poke(8'hFF, 8'hF0);   // NOP; HALT at FF
        nRst = 1'b0;
        wait_halt("t4", 40);
        check("wrap_pc", dut.pc_q, 8'h00);
        check("wrap_a", dut.a_q, 8'h01);

`ifdef UP_CORE_INT_EN
        // EI; HALT; loop back to HALT. ISR increments the output byte.
        rst_on();
        poke(8'hE0, 8'h20); poke(8'hE1, 8'hFF);   // LD FF
        poke(8'hE2, 8'h40); poke(8'hE3, 8'hE8);   // ADD E8
        poke(8'hE4, 8'h30); poke(8'hE5, 8'hFF);   // ST FF
        poke(8'hE6, 8'hE0);                       // RETI
        poke(8'hE8, 8'h01);
        poke(8'hFF, 8'h3C);
        poke(8'h00, 8'hC0); poke(8'h01, 8'hF0);   // EI; HALT
        poke(8'h02, 8'h90); poke(8'h03, 8'h01);   // JMP 01
        nRst = 1'b0;
        run(4);
        check("int_halted_ie", {dut.halted_q, dut.ie_q}, 2'b11);
        pulse_int();
        run(1);
        check("int_vector", dut.pc_q, VEC);
        run(11);
        check("reti_pc", dut.pc_q, 8'h02);
        check("reti_ie", dut.ie_q, 1'b1);
        check("isr_inc", bus_if.mem_map_out, 8'h3D);
        for (int p = 1; p < 256; p++) begin
            pulse_int();
            run(24);
        end
        check("isr_wrap", bus_if.mem_map_out, 8'h3C);
        check("isr_end_pc", dut.pc_q, 8'h02);

        // Request while IE=0 is held until EI
        rst_on();
        for (int i = 0; i < 10; i++) poke(i[7:0], 8'h00);
        poke(8'h0A, 8'hC0); poke(8'h0B, 8'hF0);   // EI; HALT
        nRst = 1'b0;
        run(2);
        pulse_int();
        run(3);
        check("held_pending", dut.pending_q, 1'b1);
        check("held_no_vector", (dut.pc_q == VEC), 1'b0);
        run(17);
        check("late_vector", dut.pc_q, VEC);
        run(13);
        check("late_return_pc", dut.pc_q, 8'h0C);
        check("late_isr_out", bus_if.mem_map_out, 8'h3D);

        // Reset in the middle of the ISR with a second request pending
        pulse_int();
        run(1);
        check("isr2_vector", dut.pc_q, VEC);
        run(3);
        pulse_int();
        check("isr2_pending", dut.pending_q, 1'b1);
        nRst = 1'b1;
        run(1);
        check("midisr_rst", {dut.pc_q, dut.ie_q, dut.pending_q}, 10'h000);
`else
        // Interrupt disabled: EI/RETI/DI are NOPs, int ignored, HALT until reset
        rst_on();
        poke(8'h00, 8'hC0); poke(8'h01, 8'hE0);   // EI; RETI
        poke(8'h02, 8'hD0); poke(8'h03, 8'hF0);   // DI; HALT
        nRst = 1'b0;
        run(8);
        check("noint_pc", dut.pc_q, 8'h04);
        check("noint_halted", dut.halted_q, 1'b1);
        pulse_int();
        run(20);
        check("noint_ignored_pc", dut.pc_q, 8'h04);
        check("noint_still_halted", dut.halted_q, 1'b1);
        rst_on();
        check("noint_rst_wakes", {dut.halted_q, dut.pc_q}, 9'h000);
`endif

        run(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
